// File: rtl/twiddle_fetch_ctrl_if.sv
// Twiddle fetch bus: ROM read port plus the twiddle beat stream.
//   rom_addr              : registered ROM address {stage[2:0], idx[1:0]}
//   rom_re_data/im_data   : ROM read data for the address presented last cycle edge
//   tw_valid/tw_ready     : beat handshake; a beat transfers on a rising clk edge
//                           where tw_valid & tw_ready. While tw_valid is high and
//                           tw_ready is low the beat payload holds steady, and
//                           tw_valid never drops without a transfer.
//   tw_re/tw_im/tw_stage/tw_idx/tw_last : payload of the current beat
// master = the fetch controller, slave = ROM + consumer side.
interface twiddle_fetch_ctrl_if #(
    parameter int DW = 16
);
    logic [4:0]    rom_addr;
    logic [DW-1:0] rom_re_data;
    logic [DW-1:0] rom_im_data;
    logic          tw_valid;
    logic          tw_ready;
    logic [DW-1:0] tw_re;
    logic [DW-1:0] tw_im;
    logic [2:0]    tw_stage;
    logic [1:0]    tw_idx;
    logic          tw_last;

    modport master (
        output rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_last,
        input  rom_re_data, rom_im_data, tw_ready
    );

    modport slave (
        input  rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_last,
        output rom_re_data, rom_im_data, tw_ready
    );
endinterface

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle fetch controller: on start, reads 4*num_stages twiddle pairs from the
// real/imaginary ROMs in address order and streams them as tagged beats.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle run request (ignored unless idle and num_stages != 0)
//   num_stages     : number of stage groups to fetch (1..7), sampled with start
//   busy           : run in progress (cycle after accepted start .. last transfer)
//   done           : one-cycle pulse the cycle after the last transfer
//   state_dbg      : current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//   bus            : ROM port and twiddle beat stream (master side)
module twiddle_fetch_ctrl #(
    parameter int DW    = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           num_stages,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg,
    twiddle_fetch_ctrl_if.master bus
);
    localparam int IDXW = $clog2(GROUP);
    localparam int AW   = 3 + IDXW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   rom_addr;
    logic            pend;       // a read was issued last edge; its data is on the ROM outputs now
    logic [2:0]      num_q;
    logic [2:0]      last_stage;
    logic [AW-1:0]   last_addr;

    // 2-entry beat FIFO
    logic [DW-1:0]   mem_re    [2];
    logic [DW-1:0]   mem_im    [2];
    logic [2:0]      mem_stage [2];
    logic [IDXW-1:0] mem_idx   [2];
    logic            mem_last  [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic            push;
    logic            pop;
    logic            valid;
    logic [2:0]      credit;
    logic            issue_ok;

    assign last_stage = num_q - 3'd1;
    assign last_addr  = {last_stage, IDXW'(GROUP - 1)};

    assign valid = (count != 2'd0);
    assign pop   = valid & bus.tw_ready;
    assign push  = pend;

    // Occupancy the next issued read will see when it lands: buffered beats
    // plus the read in flight, less the beat leaving this cycle.
    assign credit   = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    assign issue_ok = (credit < 3'd2);

    // Control FSM: owns address generation, run bookkeeping, busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            pend     <= 1'b0;
            num_q    <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (num_stages != 3'd0)) begin
                        state    <= FETCH;
                        num_q    <= num_stages;
                        rom_addr <= '0;
                        pend     <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_addr == last_addr) begin
                        state <= DRAIN;
                    end else if (issue_ok) begin
                        rom_addr <= rom_addr + AW'(1);
                        pend     <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Only the final beat carries the last tag, so its
                    // transfer closes the run.
                    if (pop && mem_last[rd_ptr]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat FIFO: captures ROM data with its stage/idx tag the cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_re[i]    <= '0;
                mem_im[i]    <= '0;
                mem_stage[i] <= '0;
                mem_idx[i]   <= '0;
                mem_last[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_re[wr_ptr]    <= bus.rom_re_data;
                mem_im[wr_ptr]    <= bus.rom_im_data;
                mem_stage[wr_ptr] <= rom_addr[AW-1:IDXW];
                mem_idx[wr_ptr]   <= rom_addr[IDXW-1:0];
                mem_last[wr_ptr]  <= (rom_addr == last_addr);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.tw_valid = valid;
    assign bus.tw_re    = mem_re[rd_ptr];
    assign bus.tw_im    = mem_im[rd_ptr];
    assign bus.tw_stage = mem_stage[rd_ptr];
    assign bus.tw_idx   = mem_idx[rd_ptr];
    assign bus.tw_last  = mem_last[rd_ptr];
    assign state_dbg    = state;
endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Bench for twiddle_fetch_ctrl: ROM model, randomized consumer, queue scoreboard.
module tb_twiddle_fetch_ctrl;
    localparam int W = 38;  // {re[15:0], im[15:0], stage[2:0], idx[1:0], last}

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] num_stages;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    twiddle_fetch_ctrl_if #(.DW(16)) bus ();

    twiddle_fetch_ctrl #(.DW(16), .GROUP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_stages (num_stages),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg),
        .bus        (bus)
    );

    int checks;
    int failures;
    int beats_rx;
    int last_cnt;
    int runs_done;
    bit rand_on;
    bit ready_set;
    logic [W-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- ROM contents ----------------
    function automatic logic [15:0] rom_re(input int a);
        return 16'((a * 293) ^ 32'h8000);
    endfunction

    function automatic logic [15:0] rom_im(input int a);
        return (a < 4) ? 16'h0000 : 16'(a * 6 + 9);
    endfunction

    always_comb begin
        bus.rom_re_data = rom_re(int'(bus.rom_addr));
        bus.rom_im_data = rom_im(int'(bus.rom_addr));
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] exp_beat(input int a, input int n);
        logic [2:0] s;
        logic [1:0] i;
        logic       l;
        s = 3'(a / 4);
        i = 2'(a % 4);
        l = (a == 4 * n - 1);
        return {rom_re(a), rom_im(a), s, i, l};
    endfunction

    task automatic model_push(input int n);
        for (int a = 0; a < 4 * n; a++) exp_q.push_back(exp_beat(a, n));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        bus.tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tw_ready = rand_on ? 1'($urandom_range(0, 1)) : ready_set;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] head;
        logic [W-1:0] hold;
        logic [W-1:0] e;
        bit have_hold;
        bit done_due;
        have_hold = 0;
        done_due  = 0;
        forever begin
            @(negedge clk);
            head = {bus.tw_re, bus.tw_im, bus.tw_stage, bus.tw_idx, bus.tw_last};
            if (!rst_n) begin
                exp_q.delete();
                have_hold = 0;
                done_due  = 0;
            end else begin
                if (done_due) begin
                    chk("done_pulse", 64'(done), 64'd1);
                    chk("busy_low_at_done", 64'(busy), 64'd0);
                    done_due = 0;
                    runs_done++;
                end else if (done) begin
                    chk("done_spurious", 64'(done), 64'd0);
                end
                if (have_hold) begin
                    chk("valid_held_on_stall", 64'(bus.tw_valid), 64'd1);
                    chk("head_stable_on_stall", 64'(head), 64'(hold));
                end
                if (bus.tw_valid && bus.tw_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%h required=none t=%0t", head, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(head), 64'(e));
                        if (e[0]) done_due = 1;
                    end
                    beats_rx++;
                    if (bus.tw_last) last_cnt++;
                end
                have_hold = bus.tw_valid && !bus.tw_ready;
                hold      = head;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int n, input bit push);
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_stages = 3'(n);
        if (push) model_push(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_runs(input int target);
        int k;
        k = 0;
        while (runs_done < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("run_completes", 64'(runs_done >= target), 64'd1);
    endtask

    // Short run with ready high: checks address order and first-beat latency
    task automatic short_run_addr_check(input string tag);
        pulse_start(1, 1);
        @(negedge clk);
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, "_addr0"}, 64'(bus.rom_addr), 64'd0);
        chk({tag, "_no_valid_yet"}, 64'(bus.tw_valid), 64'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk({tag, "_addr_seq"}, 64'(bus.rom_addr), 64'(k));
            if (k == 1) chk({tag, "_first_valid"}, 64'(bus.tw_valid), 64'd1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base_b;
        int base_l;
        int base_r;
        int k;
        logic [4:0] addr_s[5];
        checks     = 0;
        failures   = 0;
        beats_rx   = 0;
        last_cnt   = 0;
        runs_done  = 0;
        rand_on    = 0;
        ready_set  = 1;
        start      = 1'b0;
        num_stages = 3'd0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("rst_tw_valid", 64'(bus.tw_valid), 64'd0);
        chk("rst_tw_re_im", 64'({bus.tw_re, bus.tw_im}), 64'd0);
        chk("rst_tag_last", 64'({bus.tw_stage, bus.tw_idx, bus.tw_last}), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single stage group
        base_r = runs_done;
        base_b = beats_rx;
        base_l = last_cnt;
        short_run_addr_check("s1");
        wait_runs(base_r + 1);
        chk("s1_beats", 64'(beats_rx - base_b), 64'd4);
        chk("s1_last_once", 64'(last_cnt - base_l), 64'd1);

        // full 7-stage run, ready high
        base_r = runs_done;
        base_b = beats_rx;
        pulse_start(7, 1);
        wait_runs(base_r + 1);
        chk("s7_beats", 64'(beats_rx - base_b), 64'd28);

        // stall with FIFO full
        base_r = runs_done;
        base_b = beats_rx;
        pulse_start(3, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tw_valid && k < 50);
        chk("stall_first_valid_seen", 64'(bus.tw_valid), 64'd1);
        ready_set = 0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            addr_s[i] = bus.rom_addr;
        end
        chk("stall_addr_frozen_a", 64'(addr_s[3]), 64'(addr_s[2]));
        chk("stall_addr_frozen_b", 64'(addr_s[4]), 64'(addr_s[2]));
        chk("stall_valid", 64'(bus.tw_valid), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        ready_set = 1;
        wait_runs(base_r + 1);
        chk("stall_beats", 64'(beats_rx - base_b), 64'd12);

        // start while busy is ignored; start with zero stages is ignored
        base_r = runs_done;
        base_b = beats_rx;
        pulse_start(3, 1);
        repeat (2) @(posedge clk);
        pulse_start(2, 0);
        wait_runs(base_r + 1);
        repeat (10) @(negedge clk);
        chk("busy_start_beats", 64'(beats_rx - base_b), 64'd12);
        chk("busy_start_no_extra_run", 64'(runs_done - base_r), 64'd1);
        pulse_start(0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_stage_busy", 64'(busy), 64'd0);
            chk("zero_stage_valid", 64'(bus.tw_valid), 64'd0);
        end

        // reset in the middle of a 28-beat run
        base_b = beats_rx;
        pulse_start(7, 1);
        k = 0;
        while (beats_rx - base_b < 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("midrun_reached_beat10", 64'(beats_rx - base_b >= 10), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_valid", 64'(bus.tw_valid), 64'd0);
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_addr", 64'(bus.rom_addr), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base_r = runs_done;
        base_b = beats_rx;
        short_run_addr_check("post_rst");
        wait_runs(base_r + 1);
        chk("post_rst_beats", 64'(beats_rx - base_b), 64'd4);

        // random backpressure, full 7-stage run
        rand_on = 1;
        base_r = runs_done;
        base_b = beats_rx;
        base_l = last_cnt;
        pulse_start(7, 1);
        wait_runs(base_r + 1);
        chk("rand7_beats", 64'(beats_rx - base_b), 64'd28);
        chk("rand7_last_once", 64'(last_cnt - base_l), 64'd1);

        // random backpressure, random run lengths
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 7);
            base_r = runs_done;
            base_b = beats_rx;
            pulse_start(n, 1);
            wait_runs(base_r + 1);
            chk("rand_n_beats", 64'(beats_rx - base_b), 64'(4 * n));
        end
        rand_on = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(state_dbg), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/twiddle_fetch_ctrl.md
TWIDDLE_FETCH_CTRL -- requirements
Module: twiddle_fetch_ctrl

Interface
REQ-001 Parameter DW, 16, twiddle word width (real and imaginary).
REQ-002 Parameter GROUP, 4, twiddle words per stage group; ROM address = {stage[2:0], idx[1:0]}.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a fetch run.
REQ-006 num_stages  in  3  stage groups to fetch, 1..7; sampled with start.
REQ-007 rom_addr  out  5  address to real and imaginary twiddle ROMs (registered).
REQ-008 rom_re_data  in  DW  real ROM output, valid one cycle after rom_addr.
REQ-009 rom_im_data  in  DW  imaginary ROM output, valid one cycle after rom_addr.
REQ-010 tw_valid  out  1  twiddle beat available.
REQ-011 tw_ready  in  1  consumer accepts beat; transfer = tw_valid & tw_ready.
REQ-012 tw_re, tw_im  out  DW each  twiddle pair for current beat.
REQ-013 tw_stage  out  3; tw_idx  out  2  stage and index of current beat.
REQ-014 tw_last  out  1  high on final beat of run.
REQ-015 busy  out  1; done  out  1  run in progress; one-cycle completion pulse.

Function
REQ-016 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start with num_stages!=0; FETCH->DRAIN after last address issued; DRAIN->IDLE on transfer of last beat.
REQ-017 start ignored when num_stages==0 or state!=IDLE.
REQ-018 Address sequence: stage 0..num_stages-1 outer, idx 0..3 inner; rom_addr = 4*stage+idx; final address 4*num_stages-1.
REQ-019 Issue: edge that accepts start loads rom_addr=0 and marks issue; subsequent issues advance rom_addr by 1.
REQ-020 One-cycle pending flag tracks each issued read; ROM data captured with its stage/idx tag into 2-entry FIFO at end of cycle following issue.
REQ-021 Issue allowed only when fifo_count + pend - pop < 2 (pop = transfer this cycle); otherwise rom_addr holds.
REQ-022 With tw_ready held high, one beat per cycle sustained; first tw_valid in third cycle after start edge.
REQ-023 tw_valid = FIFO non-empty; tw_re/tw_im/tw_stage/tw_idx/tw_last = FIFO head; stable while tw_valid & !tw_ready.
REQ-024 Beat order strictly equals issue order; no beat dropped or duplicated under any tw_ready pattern.
REQ-025 Simultaneous FIFO push and pop: count unchanged, data order preserved.
REQ-026 busy high from cycle after accepted start through cycle of last transfer; done high exactly one cycle after last transfer, busy low that cycle.
REQ-027 tw_last asserted only on beat stage=num_stages-1, idx=3.

Reset
REQ-028 rst_n low: state=IDLE, rom_addr=0, pend=0, FIFO empty, tw_valid=0, tw_re=tw_im=0, tw_stage=tw_idx=0, tw_last=0, busy=0, done=0.
REQ-029 Reset mid-run discards all pending and buffered beats; after release block is IDLE and accepts a new start.

Verification
REQ-030 start, num_stages=1, tw_ready=1, imag ROM model -> rom_addr 0,1,2,3; 4 beats tw_im 0000,0000,0000,0000; tw_last on idx 3; done one cycle later.
REQ-031 start, num_stages=7, tw_ready=1 -> 28 consecutive beats, addresses 0..27; beat 27 tw_im=00AB, tw_stage=6, tw_idx=3, tw_last=1.
REQ-032 num_stages=3, tw_ready low 5 cycles after first beat -> rom_addr freezes with FIFO full (2), head stable; on resume remaining beats in order, 12 total.
REQ-033 start pulsed while busy with num_stages=2 -> ignored; original run completes with its beat count; start with num_stages=0 -> busy stays 0.
REQ-034 rst_n low at beat 10 of 28-beat run -> next cycle tw_valid=0, busy=0; fresh start num_stages=1 yields addresses 0..3 correctly.
REQ-035 Random tw_ready toggling over full 7-stage run -> scoreboard matches ROM contents per address, no loss, tw_last once.
